// File: rtl/basic_pkg.sv
// Shared definitions for the basic-computer datapath.
//   sel_e    : common-bus source select codes (driven on port s)
//   alu_op_e : accumulator ALU operation codes (driven on port alu_op)
//   ADDR_W   : AR/PC width, WORD_W : data word width
package basic_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned WORD_W = 16;

  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_AR   = 3'd1,
    SEL_PC   = 3'd2,
    SEL_DR   = 3'd3,
    SEL_AC   = 3'd4,
    SEL_IR   = 3'd5,
    SEL_TR   = 3'd6,
    SEL_MEM  = 3'd7
  } sel_e;

  typedef enum logic [2:0] {
    ALU_AND   = 3'd0,
    ALU_ADD   = 3'd1,
    ALU_LDA   = 3'd2,
    ALU_CMA   = 3'd3,
    ALU_CIR   = 3'd4,
    ALU_CIL   = 3'd5,
    ALU_HOLD6 = 3'd6,
    ALU_HOLD7 = 3'd7
  } alu_op_e;

endpackage

// File: rtl/basic_reg.sv
// Generic datapath register with clear / load / increment.
//   clk, rst_n : clock, asynchronous active-low reset (clears q)
//   clr        : clear to zero (highest priority)
//   ld         : load d
//   inr        : increment, wraps modulo 2^W (lowest priority)
//   d, q       : load data, register contents
module basic_reg #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         ld,
  input  logic         inr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr)      q_d = '0;
    else if (ld)  q_d = d;
    else if (inr) q_d = q_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/basic_datapath.sv
// Register/bus datapath of the basic computer: AR, PC, DR, AC, IR, TR, E and
// a word-addressed memory joined by one 16-bit common bus.
//   clk, rst_n               : clock, asynchronous active-low reset
//   s                        : bus source select (basic_pkg::sel_e)
//   ar_/pc_/dr_/ac_ strobes  : register clear / load / increment
//   alu_op                   : ALU function applied on ac_ld
//   e_clr, e_cme             : clear / complement E
//   ir_ld, tr_ld             : load IR / TR from bus
//   mem_wr                   : write bus to M[AR]
//   init_we/addr/data        : memory preload port (wins over mem_wr)
//   ir_data, bus, ac, dr, e  : observed state
//   ac_zero, ac_neg, dr_zero : status flags
module basic_datapath
  import basic_pkg::*;
#(
  parameter int unsigned MEM_AW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        s,
  input  logic              ar_ld,
  input  logic              ar_inr,
  input  logic              ar_clr,
  input  logic              pc_ld,
  input  logic              pc_inr,
  input  logic              pc_clr,
  input  logic              dr_ld,
  input  logic              dr_inr,
  input  logic              ac_ld,
  input  logic              ac_inr,
  input  logic              ac_clr,
  input  logic [2:0]        alu_op,
  input  logic              e_clr,
  input  logic              e_cme,
  input  logic              ir_ld,
  input  logic              tr_ld,
  input  logic              mem_wr,
  input  logic              init_we,
  input  logic [MEM_AW-1:0] init_addr,
  input  logic [15:0]       init_data,
  output logic [15:0]       ir_data,
  output logic [15:0]       bus,
  output logic [15:0]       ac,
  output logic [15:0]       dr,
  output logic              e,
  output logic              ac_zero,
  output logic              ac_neg,
  output logic              dr_zero
);

  logic [ADDR_W-1:0] ar, pc;
  logic [WORD_W-1:0] ir, tr;
  logic [WORD_W-1:0] ac_q, ac_d;
  logic              e_q, e_d;
  logic [WORD_W-1:0] mem_q [2**MEM_AW];
  logic [WORD_W-1:0] mem_rd;

  logic [WORD_W-1:0] alu_ac;
  logic              alu_e;
  logic              alu_e_upd;
  logic [WORD_W:0]   sum;

  // ---------------- registers ----------------
  basic_reg #(.W(ADDR_W)) u_ar (
    .clk(clk), .rst_n(rst_n), .clr(ar_clr), .ld(ar_ld), .inr(ar_inr),
    .d(bus[ADDR_W-1:0]), .q(ar)
  );

  basic_reg #(.W(ADDR_W)) u_pc (
    .clk(clk), .rst_n(rst_n), .clr(pc_clr), .ld(pc_ld), .inr(pc_inr),
    .d(bus[ADDR_W-1:0]), .q(pc)
  );

  basic_reg #(.W(WORD_W)) u_dr (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .ld(dr_ld), .inr(dr_inr),
    .d(bus), .q(dr)
  );

  basic_reg #(.W(WORD_W)) u_ir (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .ld(ir_ld), .inr(1'b0),
    .d(bus), .q(ir)
  );

  basic_reg #(.W(WORD_W)) u_tr (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .ld(tr_ld), .inr(1'b0),
    .d(bus), .q(tr)
  );

  // ---------------- common bus ----------------
  assign mem_rd = mem_q[ar[MEM_AW-1:0]];

  always_comb begin
    bus = '0;
    case (sel_e'(s))
      SEL_NONE: bus = '0;
      SEL_AR:   bus = WORD_W'(ar);
      SEL_PC:   bus = WORD_W'(pc);
      SEL_DR:   bus = dr;
      SEL_AC:   bus = ac_q;
      SEL_IR:   bus = ir;
      SEL_TR:   bus = tr;
      SEL_MEM:  bus = mem_rd;
      default:  bus = '0;
    endcase
  end

  // ---------------- ALU ----------------
  assign sum = {1'b0, ac_q} + {1'b0, dr};

  always_comb begin
    alu_ac    = ac_q;
    alu_e     = e_q;
    alu_e_upd = 1'b0;
    case (alu_op_e'(alu_op))
      ALU_AND: alu_ac = ac_q & dr;
      ALU_ADD: begin
        alu_ac    = sum[WORD_W-1:0];
        alu_e     = sum[WORD_W];
        alu_e_upd = 1'b1;
      end
      ALU_LDA: alu_ac = dr;
      ALU_CMA: alu_ac = ~ac_q;
      ALU_CIR: begin
        alu_ac    = {e_q, ac_q[WORD_W-1:1]};
        alu_e     = ac_q[0];
        alu_e_upd = 1'b1;
      end
      ALU_CIL: begin
        alu_ac    = {ac_q[WORD_W-2:0], e_q};
        alu_e     = ac_q[WORD_W-1];
        alu_e_upd = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------- AC and E ----------------
  // E follows the ALU carry/rotate whenever ac_ld fires with a carry-producing
  // op, independent of whether ac_clr overrides the AC result itself.
  always_comb begin
    ac_d = ac_q;
    if (ac_clr)      ac_d = '0;
    else if (ac_ld)  ac_d = alu_ac;
    else if (ac_inr) ac_d = ac_q + WORD_W'(1);

    e_d = e_q;
    if (e_clr)                   e_d = 1'b0;
    else if (e_cme)              e_d = ~e_q;
    else if (ac_ld && alu_e_upd) e_d = alu_e;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac_q <= '0;
      e_q  <= 1'b0;
    end else begin
      ac_q <= ac_d;
      e_q  <= e_d;
    end
  end

  // ---------------- memory (not reset) ----------------
  // The preload write is issued last so it wins when both hit one address.
  always_ff @(posedge clk) begin
    if (mem_wr)  mem_q[ar[MEM_AW-1:0]] <= bus;
    if (init_we) mem_q[init_addr]      <= init_data;
  end

  // ---------------- outputs ----------------
  assign ir_data = ir;
  assign ac      = ac_q;
  assign e       = e_q;
  assign ac_zero = (ac_q == '0);
  assign ac_neg  = ac_q[WORD_W-1];
  assign dr_zero = (dr == '0);

endmodule

// File: tb/tb_basic_datapath.sv
module tb_basic_datapath;

  logic        clk;
  logic        rst_n;
  logic [2:0]  s;
  logic        ar_ld, ar_inr, ar_clr;
  logic        pc_ld, pc_inr, pc_clr;
  logic        dr_ld, dr_inr;
  logic        ac_ld, ac_inr, ac_clr;
  logic [2:0]  alu_op;
  logic        e_clr, e_cme;
  logic        ir_ld, tr_ld;
  logic        mem_wr;
  logic        init_we;
  logic [7:0]  init_addr;
  logic [15:0] init_data;
  logic [15:0] ir_data, bus, ac, dr;
  logic        e, ac_zero, ac_neg, dr_zero;

  basic_datapath #(.MEM_AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .s(s),
    .ar_ld(ar_ld), .ar_inr(ar_inr), .ar_clr(ar_clr),
    .pc_ld(pc_ld), .pc_inr(pc_inr), .pc_clr(pc_clr),
    .dr_ld(dr_ld), .dr_inr(dr_inr),
    .ac_ld(ac_ld), .ac_inr(ac_inr), .ac_clr(ac_clr),
    .alu_op(alu_op), .e_clr(e_clr), .e_cme(e_cme),
    .ir_ld(ir_ld), .tr_ld(tr_ld), .mem_wr(mem_wr),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .ir_data(ir_data), .bus(bus), .ac(ac), .dr(dr), .e(e),
    .ac_zero(ac_zero), .ac_neg(ac_neg), .dr_zero(dr_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  s;
    logic        ar_ld, ar_inr, ar_clr, pc_ld, pc_inr, pc_clr, dr_ld, dr_inr;
    logic        ac_ld, ac_inr, ac_clr;
    logic [2:0]  alu_op;
    logic        e_clr, e_cme, ir_ld, tr_ld, mem_wr, init_we;
    logic [7:0]  init_addr;
    logic [15:0] init_data;
  } stim_t;

  typedef struct packed {
    logic [15:0] bus, ac, dr, ir;
    logic        e, az, an, dz;
  } snap_t;

  snap_t exp_q[$];
  int    n_chk  = 0;
  int    n_fail = 0;

  // reference model state (plain integers)
  int unsigned m_ar, m_pc, m_dr, m_ac, m_ir, m_tr, m_e;
  int unsigned m_mem[256];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  task automatic drive(input stim_t st);
    s = st.s;
    ar_ld = st.ar_ld; ar_inr = st.ar_inr; ar_clr = st.ar_clr;
    pc_ld = st.pc_ld; pc_inr = st.pc_inr; pc_clr = st.pc_clr;
    dr_ld = st.dr_ld; dr_inr = st.dr_inr;
    ac_ld = st.ac_ld; ac_inr = st.ac_inr; ac_clr = st.ac_clr;
    alu_op = st.alu_op; e_clr = st.e_clr; e_cme = st.e_cme;
    ir_ld = st.ir_ld; tr_ld = st.tr_ld; mem_wr = st.mem_wr;
    init_we = st.init_we; init_addr = st.init_addr; init_data = st.init_data;
  endtask

  function automatic int unsigned bus_of(input logic [2:0] sel);
    case (sel)
      3'd1:    return m_ar;
      3'd2:    return m_pc;
      3'd3:    return m_dr;
      3'd4:    return m_ac;
      3'd5:    return m_ir;
      3'd6:    return m_tr;
      3'd7:    return m_mem[m_ar % 256];
      default: return 0;
    endcase
  endfunction

  function automatic void model_reset();
    m_ar = 0; m_pc = 0; m_dr = 0; m_ac = 0; m_ir = 0; m_tr = 0; m_e = 0;
  endfunction

  // Drive one cycle of strobes at the falling edge, queue what the outputs
  // must show during this cycle, then advance the model past the next edge.
  task automatic step(input stim_t st);
    int unsigned b, n_ar, n_pc, n_dr, n_ac, n_e, n_ir, n_tr, a_ac, a_e, sm;
    bit a_upd;
    snap_t sn;
    @(negedge clk);
    drive(st);
    b = bus_of(st.s);
    sn.bus = 16'(b); sn.ac = 16'(m_ac); sn.dr = 16'(m_dr); sn.ir = 16'(m_ir);
    sn.e = (m_e != 0); sn.az = (m_ac == 0); sn.an = (m_ac >= 32768); sn.dz = (m_dr == 0);
    exp_q.push_back(sn);

    n_ar = st.ar_clr ? 0 : st.ar_ld ? b % 4096 : st.ar_inr ? (m_ar + 1) % 4096 : m_ar;
    n_pc = st.pc_clr ? 0 : st.pc_ld ? b % 4096 : st.pc_inr ? (m_pc + 1) % 4096 : m_pc;
    n_dr = st.dr_ld ? b : st.dr_inr ? (m_dr + 1) % 65536 : m_dr;
    n_ir = st.ir_ld ? b : m_ir;
    n_tr = st.tr_ld ? b : m_tr;

    a_ac = m_ac; a_e = m_e; a_upd = 0;
    case (st.alu_op)
      3'd0: a_ac = m_ac & m_dr;
      3'd1: begin sm = m_ac + m_dr; a_ac = sm % 65536; a_e = sm / 65536; a_upd = 1; end
      3'd2: a_ac = m_dr;
      3'd3: a_ac = 65535 - m_ac;
      3'd4: begin a_ac = m_e * 32768 + m_ac / 2; a_e = m_ac % 2; a_upd = 1; end
      3'd5: begin a_ac = (m_ac * 2) % 65536 + m_e; a_e = m_ac / 32768; a_upd = 1; end
      default: ;
    endcase
    n_ac = st.ac_clr ? 0 : st.ac_ld ? a_ac : st.ac_inr ? (m_ac + 1) % 65536 : m_ac;
    n_e  = st.e_clr ? 0 : st.e_cme ? 1 - m_e : (st.ac_ld && a_upd) ? a_e : m_e;

    if (st.mem_wr)  m_mem[m_ar % 256] = b;
    if (st.init_we) m_mem[st.init_addr] = st.init_data;
    m_ar = n_ar; m_pc = n_pc; m_dr = n_dr; m_ac = n_ac;
    m_ir = n_ir; m_tr = n_tr; m_e = n_e;
  endtask

  // Async reset between clock edges: every register must read 0 at once.
  task automatic do_reset();
    stim_t st;
    st = '0;
    @(posedge clk);
    #2;
    drive(st);
    rst_n = 1'b0;
    #1;
    chk("rst_ac", ac, 16'h0000);
    chk("rst_dr", dr, 16'h0000);
    chk("rst_ir", ir_data, 16'h0000);
    chk("rst_e", 16'(e), 16'h0000);
    chk("rst_ac_zero", 16'(ac_zero), 16'h0001);
    s = 3'd1; #1; chk("rst_ar", bus, 16'h0000);
    s = 3'd2; #1; chk("rst_pc", bus, 16'h0000);
    s = 3'd6; #1; chk("rst_tr", bus, 16'h0000);
    s = 3'd0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // monitor: compares whatever the driver queued for this cycle
  initial begin
    snap_t x;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("bus", bus, x.bus);
        chk("ac", ac, x.ac);
        chk("dr", dr, x.dr);
        chk("ir_data", ir_data, x.ir);
        chk("e", 16'(e), 16'(x.e));
        chk("ac_zero", 16'(ac_zero), 16'(x.az));
        chk("ac_neg", 16'(ac_neg), 16'(x.an));
        chk("dr_zero", 16'(dr_zero), 16'(x.dz));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t st;
    st = '0;
    rst_n = 1'b0;
    drive(st);
    model_reset();
    #1;
    chk("por_ir", ir_data, 16'h0000);
    chk("por_ac_zero", 16'(ac_zero), 16'h0001);
    @(negedge clk);
    rst_n = 1'b1;

    // preload all of memory so every read is known
    for (int unsigned a = 0; a < 256; a++) begin
      st = '0; st.init_we = 1'b1; st.init_addr = 8'(a); st.init_data = 16'($urandom);
      if (a == 0)    st.init_data = 16'h0010;
      if (a == 'h10) st.init_data = 16'h1234;
      if (a == 'h21) st.init_data = 16'h5A5A;
      step(st);
    end

    // fetch: PC <- M[0]=0x010, then T0 / T1
    st = '0; st.s = 3'd7; st.pc_ld = 1'b1; step(st);
    st = '0; st.s = 3'd2; st.ar_ld = 1'b1; step(st);
    st = '0; st.s = 3'd7; st.ir_ld = 1'b1; st.pc_inr = 1'b1; step(st);
    st = '0; st.s = 3'd1; step(st);
    #2; chk("fetch_ar", bus, 16'h0010); chk("fetch_ir", ir_data, 16'h1234);
    s = 3'd2; #1; chk("fetch_pc", bus, 16'h0011);

    // ADD 0xFFFF + 0x0001
    st = '0; st.dr_ld = 1'b1; st.ac_clr = 1'b1; step(st);
    st = '0; st.dr_inr = 1'b1; st.ac_ld = 1'b1; st.alu_op = 3'd3; step(st);
    st = '0; st.ac_ld = 1'b1; st.alu_op = 3'd1; step(st);
    st = '0; step(st);
    #2; chk("add_ac", ac, 16'h0000); chk("add_e", 16'(e), 16'h0001);
    chk("add_ac_zero", 16'(ac_zero), 16'h0001);

    // rotates from AC=0x8001, E=0
    st = '0; st.ac_clr = 1'b1; st.e_clr = 1'b1; step(st);
    st = '0; st.ac_inr = 1'b1; st.e_cme = 1'b1; step(st);
    st = '0; st.ac_ld = 1'b1; st.alu_op = 3'd4; step(st);
    st = '0; st.ac_inr = 1'b1; st.e_clr = 1'b1; step(st);
    st = '0; st.ac_ld = 1'b1; st.alu_op = 3'd5; step(st);
    #2; chk("pre_rot_ac", ac, 16'h8001); chk("pre_rot_e", 16'(e), 16'h0000);
    st = '0; st.ac_ld = 1'b1; st.alu_op = 3'd4; step(st);
    #2; chk("cil_ac", ac, 16'h0002); chk("cil_e", 16'(e), 16'h0001);
    st = '0; step(st);
    #2; chk("cir_ac", ac, 16'h8001); chk("cir_e", 16'(e), 16'h0000);

    // PC wrap and clr>ld>inr priority
    st = '0; st.ac_clr = 1'b1; step(st);
    st = '0; st.ac_ld = 1'b1; st.alu_op = 3'd3; step(st);
    st = '0; st.s = 3'd4; st.pc_ld = 1'b1; step(st);
    st = '0; st.pc_inr = 1'b1; step(st);
    st = '0; st.s = 3'd2; st.pc_ld = 1'b1; step(st);
    #2; chk("pc_wrap", bus, 16'h0000);
    st = '0; st.s = 3'd4; st.pc_ld = 1'b1; step(st);
    st = '0; st.s = 3'd4; st.pc_clr = 1'b1; st.pc_ld = 1'b1; st.pc_inr = 1'b1; step(st);
    st = '0; st.s = 3'd2; step(st);
    #2; chk("pc_prio", bus, 16'h0000);

    // write hazard: mem_wr uses the pre-edge AR
    st = '0; st.ar_clr = 1'b1; st.init_we = 1'b1; st.init_addr = 8'h00; st.init_data = 16'hBEEF; step(st);
    st = '0; st.s = 3'd7; st.dr_ld = 1'b1; st.init_we = 1'b1; st.init_addr = 8'h00; st.init_data = 16'h0020; step(st);
    st = '0; st.s = 3'd7; st.ar_ld = 1'b1; st.ac_ld = 1'b1; st.alu_op = 3'd2; step(st);
    st = '0; st.s = 3'd4; st.mem_wr = 1'b1; st.ar_inr = 1'b1; step(st);
    st = '0; st.s = 3'd7; step(st);
    #2; chk("hz_m21", bus, 16'h5A5A);
    s = 3'd1; #1; chk("hz_ar", bus, 16'h0021);
    st = '0; st.ar_clr = 1'b1; step(st);
    st = '0; st.s = 3'd7; st.ar_ld = 1'b1; step(st);
    st = '0; st.s = 3'd7; step(st);
    #2; chk("hz_m20", bus, 16'hBEEF);

    do_reset();

    // randomized traffic with a reset in the middle
    for (int unsigned i = 0; i < 2000; i++) begin
      if (i == 1000) do_reset();
      st = '0;
      st.s = 3'($urandom_range(0, 7));
      st.ar_ld  = ($urandom_range(0, 3) == 0);
      st.ar_inr = ($urandom_range(0, 3) == 0);
      st.ar_clr = ($urandom_range(0, 15) == 0);
      st.pc_ld  = ($urandom_range(0, 3) == 0);
      st.pc_inr = ($urandom_range(0, 3) == 0);
      st.pc_clr = ($urandom_range(0, 15) == 0);
      st.dr_ld  = ($urandom_range(0, 3) == 0);
      st.dr_inr = ($urandom_range(0, 3) == 0);
      st.ac_ld  = ($urandom_range(0, 2) == 0);
      st.ac_inr = ($urandom_range(0, 3) == 0);
      st.ac_clr = ($urandom_range(0, 15) == 0);
      st.alu_op = 3'($urandom_range(0, 7));
      st.e_clr  = ($urandom_range(0, 15) == 0);
      st.e_cme  = ($urandom_range(0, 7) == 0);
      st.ir_ld  = ($urandom_range(0, 3) == 0);
      st.tr_ld  = ($urandom_range(0, 3) == 0);
      st.mem_wr = ($urandom_range(0, 3) == 0);
      st.init_we = ($urandom_range(0, 7) == 0);
      st.init_addr = ($urandom_range(0, 1) == 0) ? 8'(m_ar % 256) : 8'($urandom_range(0, 255));
      st.init_data = 16'($urandom);
      step(st);
    end

    st = '0; step(st);
    repeat (3) @(negedge clk);
    #2;
    chk("queue_drained", 16'(exp_q.size()), 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
